// File: rtl/alu_seq_reg.sv
// Registered ALU with accumulator feedback and a WIDTH-cycle shift-add multiply.
// Optional: define ALU_SEQ_FLAGS_EN to add the registered {Z,C,N,V} flags output.
module alu_seq_reg #(
  parameter int WIDTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic               b_sel,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] result
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic [3:0]         flags
`endif
);

  localparam int W2  = 2 * WIDTH;
  localparam int SHW = $clog2(2 * WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_LOGIC = 3'b010;
  localparam logic [2:0] OP_ORRED = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_CAT   = 3'b101;
  localparam logic [2:0] OP_SHL   = 3'b110;

  logic [0:0]       state_reg;
  logic [W2-1:0]    result_reg;
  logic             done_reg;
  logic [W2-1:0]    acc_reg;
  logic [W2-1:0]    mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [CW-1:0]    cnt_reg;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [W2-1:0]    single_res;
  logic [W2-1:0]    acc_step;
  logic [W2-1:0]    new_res;
  logic             accept;
  logic             mul_last;
  logic             upd;

  always_comb begin
    // Accumulator mode reads the result as it stood before this update.
    b_eff = b_sel ? result_reg[WIDTH-1:0] : b;
    sum   = {1'b0, a} + {1'b0, b_eff};
    diff  = {1'b0, a} - {1'b0, b_eff};

    single_res = result_reg;
    case (op)
      OP_ADD:   single_res = {{(WIDTH-1){1'b0}}, sum};
      OP_SUB:   single_res = {{(WIDTH-1){1'b0}}, diff};
      OP_LOGIC: single_res = {~(a & b_eff), ~(a ^ b_eff)};
      OP_ORRED: single_res = {{WIDTH{1'b0}}, {WIDTH{|{a, b_eff}}}};
      OP_CAT:   single_res = {a, ~b_eff};
      OP_SHL:   single_res = result_reg << a[SHW-1:0];
      default:  single_res = result_reg;
    endcase

    acc_step = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
    accept   = start && (state_reg == IDLE);
    mul_last = (cnt_reg == CW'(WIDTH - 1));
    upd      = (accept && (op != OP_MUL)) || ((state_reg == MUL) && mul_last);
    new_res  = (state_reg == MUL) ? acc_step : single_res;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      result_reg <= '0;
      done_reg   <= 1'b0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      done_reg <= upd;
      if (upd) begin
        result_reg <= new_res;
      end
      case (state_reg)
        IDLE: begin
          if (accept && (op == OP_MUL)) begin
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b_eff;
            cnt_reg    <= '0;
            state_reg  <= MUL;
          end
        end
        MUL: begin
          // One multiplier bit per clock, LSB first.
          acc_reg    <= acc_step;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (mul_last) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ready  = (state_reg == IDLE);
  assign done   = done_reg;
  assign result = result_reg;

`ifdef ALU_SEQ_FLAGS_EN
  logic [3:0] flags_reg;
  logic       v_next;

  always_comb begin
    v_next = 1'b0;
    if (state_reg == IDLE) begin
      if (op == OP_ADD)
        v_next = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      else if (op == OP_SUB)
        v_next = (a[WIDTH-1] != b_eff[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      flags_reg <= 4'b0000;
    end else if (upd) begin
      flags_reg <= {(new_res == '0), new_res[WIDTH], new_res[WIDTH-1], v_next};
    end
  end

  assign flags = flags_reg;
`endif

endmodule

// File: tb/tb_alu_seq_reg.sv
// Scoreboard bench for alu_seq_reg (WIDTH=4): stimulus pushes expectations, a
// negedge monitor pops and compares on every done pulse.
module tb_alu_seq_reg;
  localparam int WIDTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'b000;
  logic       b_sel = 1'b0;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic       ready;
  logic       done;
  logic [7:0] result;
`ifdef ALU_SEQ_FLAGS_EN
  logic [3:0] flags;
`endif

  always #5 clock = ~clock;

  alu_seq_reg #(.WIDTH(WIDTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .b_sel  (b_sel),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .done   (done),
    .result (result)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .flags  (flags)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_res_q[$];
  logic [3:0] exp_flg_q[$];
  string      exp_name_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse consumes exactly one expectation.
  always @(negedge clock) begin : mon
    string      nm;
    logic [7:0] er;
    logic [3:0] ef;
    if (reset === 1'b0 && done === 1'b1) begin
      if (exp_res_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 result=0x%02h, required no done", result);
      end else begin
        nm = exp_name_q.pop_front();
        er = exp_res_q.pop_front();
        ef = exp_flg_q.pop_front();
        check({nm, "_result"}, {24'h0, result}, {24'h0, er});
`ifdef ALU_SEQ_FLAGS_EN
        check({nm, "_flags"}, {28'h0, flags}, {28'h0, ef});
`endif
        $display("txn %s: result=0x%02h expected=0x%02h flags_exp=0x%0h", nm, result, er, ef);
      end
    end
  end

  task automatic issue(input string nm, input logic [2:0] o, input logic [3:0] ai,
                       input logic [3:0] bi, input logic bs,
                       input logic [7:0] er, input logic [3:0] ef);
    int k;
    k = 0;
    while (ready !== 1'b1 && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (ready !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_ready_timeout: got ready=%b, required 1", nm, ready);
    end
    op = o; a = ai; b = bi; b_sel = bs; start = 1'b1;
    exp_name_q.push_back(nm);
    exp_res_q.push_back(er);
    exp_flg_q.push_back(ef);
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_result"}, {24'h0, result}, 32'h0);
    check({nm, "_ready"}, {31'h0, ready}, 32'h1);
    check({nm, "_done"}, {31'h0, done}, 32'h0);
`ifdef ALU_SEQ_FLAGS_EN
    check({nm, "_flags"}, {28'h0, flags}, 32'h0);
`endif
  endtask

  initial begin
    int k;
    // Reset for 2 cycles with start asserted.
    reset = 1'b1; start = 1'b1; op = 3'b000; a = 4'h1; b = 4'h1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    check_idle("reset");

    // Back-to-back single-cycle ops.
    issue("add_9_8",   3'b000, 4'h9, 4'h8, 1'b0, 8'h11, 4'h5);
    issue("sub_2_5",   3'b001, 4'h2, 4'h5, 1'b0, 8'h1D, 4'h6);
    issue("logic_a_c", 3'b010, 4'hA, 4'hC, 1'b0, 8'h79, 4'h6);
    issue("cat_3_5",   3'b101, 4'h3, 4'h5, 1'b0, 8'h3A, 4'h6);

    // MUL with start held high the whole time.
    op = 3'b100; a = 4'hF; b = 4'hF; b_sel = 1'b0; start = 1'b1;
    exp_name_q.push_back("mul_15_15");
    exp_res_q.push_back(8'hE1);
    exp_flg_q.push_back(4'h0);
    @(posedge clock);
    @(negedge clock);
    check("mul_busy_0", {31'h0, ready}, 32'h0);
    a = 4'h0; b = 4'h0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("mul_busy_%0d", i), {31'h0, ready}, 32'h0);
    end
    @(negedge clock);
    check("mul_ready_back", {31'h0, ready}, 32'h1);
    start = 1'b0;

    // Fresh reset, then accumulate.
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_idle("reset2");
    issue("acc_1",  3'b000, 4'h3, 4'hF, 1'b1, 8'h03, 4'h0);
    issue("acc_2",  3'b000, 4'h3, 4'hF, 1'b1, 8'h06, 4'h0);
    issue("acc_3",  3'b000, 4'h3, 4'hF, 1'b1, 8'h09, 4'h3);
    issue("shl_2",  3'b110, 4'h2, 4'h0, 1'b0, 8'h24, 4'h0);
    issue("shl_0",  3'b110, 4'h0, 4'h0, 1'b0, 8'h24, 4'h0);
    issue("nop_1",  3'b111, 4'h5, 4'h5, 1'b0, 8'h24, 4'h0);

    // MUL aborted by reset at iteration 2: no done expected.
    op = 3'b100; a = 4'h3; b = 4'h2; b_sel = 1'b0; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_idle("mul_abort");
    repeat (8) @(negedge clock);
    check("mul_abort_quiet", {24'h0, result}, 32'h0);

    // Boundary values and MUL fed from the result register.
    issue("orred_0",  3'b011, 4'h0, 4'h0, 1'b0, 8'h00, 4'h8);
    issue("nop_2",    3'b111, 4'h0, 4'h0, 1'b0, 8'h00, 4'h8);
    issue("orred_1",  3'b011, 4'h0, 4'h1, 1'b0, 8'h0F, 4'h2);
    issue("mul_acc",  3'b100, 4'h5, 4'h0, 1'b1, 8'h4B, 4'h2);
    issue("sub_7_7",  3'b001, 4'h7, 4'h7, 1'b0, 8'h00, 4'h8);
    issue("add_f_1",  3'b000, 4'hF, 4'h1, 1'b0, 8'h10, 4'h4);

    k = 0;
    while (exp_res_q.size() != 0 && k < 20) begin
      @(negedge clock);
      k++;
    end
    repeat (3) @(negedge clock);
    check("drain_pending", exp_res_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
